// File: rtl/store_align_unit.sv
// Store-path aligner: rotates store data onto bus lanes, builds byte enables and splits
// stores that cross a bus word into two beats. Optional macro: STORE_MISALIGN_TRAP_EN.
module store_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              store_done,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  split_count
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  state_t state_q, state_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // mem_* stay stable while mem_valid is high and mem_ready is low.
  logic [1:0]        size_eff;
  logic [3:0]        s_bytes;
  logic [OW-1:0]     off;
  logic [ADDR_W-1:0] base;
  logic [2*NB-1:0]   lanes_wide;
  logic [XLEN-1:0]   rot_data;
  logic              is_split;
  logic [NB-1:0]     be_hi_q;
  logic              split_q;

  assign off      = req_addr[OW-1:0];
  assign base     = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign s_bytes  = 4'd1 << size_eff;
  assign is_split = |lanes_wide[2*NB-1:NB];

  always_comb begin
    size_eff = req_size;
    if (XLEN == 32 && req_size == 2'b11) size_eff = 2'b10;
  end

  // Lanes off..off+S-1 in a double-width mask; the upper half is the second beat.
  always_comb begin
    lanes_wide = '0;
    rot_data   = '0;
    for (int l = 0; l < 2*NB; l++) begin
      for (int k = 0; k < NB; k++) begin
        if (k < int'(s_bytes) && l == k + int'(off)) lanes_wide[l] = 1'b1;
      end
    end
    for (int l = 0; l < NB; l++) begin
      for (int k = 0; k < NB; k++) begin
        if (OW'(k) + off == OW'(l)) rot_data[l*8 +: 8] = req_data[k*8 +: 8];
      end
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic [3:0] off_ext;
  logic       misaligned;
  logic       mis_q;
  assign off_ext      = 4'(off);
  assign misaligned   = |(off_ext & (s_bytes - 4'd1));
  assign misalign_err = mis_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign mem_valid = (state_q != IDLE);
  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef STORE_MISALIGN_TRAP_EN
          if (!misaligned) state_d = BEAT0;
`else
          state_d = BEAT0;
`endif
        end
      end
      BEAT0:   if (mem_ready) state_d = split_q ? BEAT1 : IDLE;
      BEAT1:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      be_hi_q     <= '0;
      split_q     <= 1'b0;
      store_done  <= 1'b0;
      split_count <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      store_done <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
`ifdef STORE_MISALIGN_TRAP_EN
            if (misaligned) mis_q <= 1'b1;
`endif
            mem_addr  <= base;
            mem_be    <= lanes_wide[NB-1:0];
            be_hi_q   <= lanes_wide[2*NB-1:NB];
            split_q   <= is_split;
            mem_wdata <= rot_data;
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (split_q) begin
              mem_addr <= mem_addr + ADDR_W'(NB);
              mem_be   <= be_hi_q;
              if (split_count != '1) split_count <= split_count + 1'b1;
            end else begin
              store_done <= 1'b1;
            end
          end
        end
        BEAT1:   if (mem_ready) store_done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: directed literal stores, then random traffic against a
// byte-level reference model with an expected-beat queue checked every cycle.
module tb_store_align_unit;
  localparam int XLEN = 32, ADDR_W = 32, CNT_W = 16, NB = 4;

  logic              clk, rst;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_data;
  logic [1:0]        req_size;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              store_done, misalign_err;
  logic [CNT_W-1:0]  split_count;

  store_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .store_done(store_done),
    .misalign_err(misalign_err), .split_count(split_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: {first_beat_of_split, addr, be, wdata}
  logic [68:0]      exp_q[$];
  logic             done_exp = 1'b0;
  logic             mis_exp  = 1'b0;
  logic [CNT_W-1:0] cnt_exp  = '0;
  bit               armed    = 1'b0;

  task automatic model_accept(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int s, off;
    logic [31:0] w, base;
    logic [3:0] be0, be1;
    s    = 1 << ((sz == 2'd3) ? 2 : int'(sz));
    off  = int'(a % NB);
    base = a - (a % NB);
`ifdef STORE_MISALIGN_TRAP_EN
    if (a % s != 0) begin
      mis_exp = 1'b1;
      return;
    end
`endif
    for (int l = 0; l < NB; l++) w[l*8 +: 8] = d[((l - off + NB) % NB)*8 +: 8];
    be0 = '0;
    be1 = '0;
    for (int k = 0; k < s; k++) begin
      if (off + k < NB) be0[off + k] = 1'b1;
      else be1[off + k - NB] = 1'b1;
    end
    exp_q.push_back({be1 != 0, base, be0, w});
    if (be1 != 0) exp_q.push_back({1'b0, base + 32'(NB), be1, w});
  endtask

  // compare process, then advance the model by the events of the coming edge
  always @(negedge clk) begin
    logic [68:0] b;
    if (armed) begin
      chk("req_ready", req_ready, (exp_q.size() == 0) && !rst);
      chk("mem_valid", mem_valid, exp_q.size() != 0);
      if (exp_q.size() != 0 && mem_valid) begin
        chk("mem_addr", mem_addr, exp_q[0][67:36]);
        chk("mem_be", mem_be, exp_q[0][35:32]);
        chk("mem_wdata", mem_wdata, exp_q[0][31:0]);
      end
      chk("store_done", store_done, done_exp);
      chk("misalign_err", misalign_err, mis_exp);
      chk("split_count", split_count, cnt_exp);
    end
    if (rst) begin
      armed = 1'b1;
      exp_q.delete();
      done_exp = 1'b0;
      mis_exp  = 1'b0;
      cnt_exp  = '0;
    end else if (armed) begin
      done_exp = 1'b0;
      mis_exp  = 1'b0;
      if (exp_q.size() != 0 && mem_ready) begin
        b = exp_q.pop_front();
        if (b[68] && cnt_exp != '1) cnt_exp = cnt_exp + 1'b1;
        if (exp_q.size() == 0) done_exp = 1'b1;
      end else if (exp_q.size() == 0 && req_valid) begin
        model_accept(req_addr, req_data, req_size);
      end
    end
  end

  // driver tasks
  task automatic wait_valid();
    int t = 0;
    @(negedge clk);
    while (!mem_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("beat_timeout", mem_valid, 1'b1);
  endtask

  task automatic store_lit(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input int nbeats, input logic [31:0] a0, input logic [3:0] be0,
                           input logic [31:0] w, input logic [31:0] a1, input logic [3:0] be1,
                           input logic [CNT_W-1:0] cnt);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz; mem_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid();
    chk("lit_addr0", mem_addr, a0);
    chk("lit_be0", mem_be, be0);
    chk("lit_wdata0", mem_wdata, w);
    @(posedge clk); #1;
    if (nbeats == 2) begin
      wait_valid();
      chk("lit_addr1", mem_addr, a1);
      chk("lit_be1", mem_be, be1);
      chk("lit_wdata1", mem_wdata, w);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lit_done", store_done, 1'b1);
    chk("lit_split_count", split_count, cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_done", store_done, 1'b0);
    chk("rst_mis", misalign_err, 1'b0);
    chk("rst_count", split_count, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    store_lit(32'h1000, 32'hAABBCCDD, 2'd2, 1, 32'h1000, 4'b1111, 32'hAABBCCDD, 32'h0, 4'h0, 16'd0);
    store_lit(32'h1003, 32'h000000EE, 2'd0, 1, 32'h1000, 4'b1000, 32'hEE000000, 32'h0, 4'h0, 16'd0);
    store_lit(32'h1002, 32'h11223344, 2'd2, 2, 32'h1000, 4'b1100, 32'h33441122, 32'h1004, 4'b0011, 16'd1);
    store_lit(32'h1003, 32'h0000BEEF, 2'd1, 2, 32'h1000, 4'b1000, 32'hEF0000BE, 32'h1004, 4'b0001, 16'd2);
    store_lit(32'hFFFFFFFF, 32'h0000BEEF, 2'd1, 2, 32'hFFFFFFFC, 4'b1000, 32'hEF0000BE, 32'h0, 4'b0001, 16'd3);
`ifdef STORE_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_addr = 32'h1001; req_data = 32'h0000BEEF; req_size = 2'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("trap_no_beat", mem_valid, 1'b0);
    chk("trap_err", misalign_err, 1'b1);
    @(negedge clk);
    chk("trap_err_pulse", misalign_err, 1'b0);
    chk("trap_no_done", store_done, 1'b0);
    chk("trap_count", split_count, 16'd3);
    @(posedge clk); #1;
`else
    store_lit(32'h1001, 32'h0000BEEF, 2'd1, 1, 32'h1000, 4'b0110, 32'h00BEEF00, 32'h0, 4'h0, 16'd3);
`endif

    // hold mem_ready low in BEAT0, then reset during BEAT1
    mem_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h1002; req_data = 32'h11223344; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", mem_valid, 1'b1);
      chk("hold_addr", mem_addr, 32'h1000);
      chk("hold_be", mem_be, 4'b1100);
      chk("hold_wdata", mem_wdata, 32'h33441122);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("b1_addr", mem_addr, 32'h1004);
    chk("b1_count", split_count, 16'd4);
    @(negedge clk);
    chk("rst_b1_valid", mem_valid, 1'b0);
    chk("rst_b1_done", store_done, 1'b0);
    chk("rst_b1_count", split_count, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_b1_no_done", store_done, 1'b0);
    @(posedge clk); #1;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : $urandom;
      req_data  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      mem_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rst = 1'b0; mem_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", mem_valid, 1'b0);
    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
